ula_seq_seg: RTL and testbench
==============================

Name: ula_seq_seg

Overview:
Parametrised signed sequential ALU with an accumulating result register, a start/busy/done handshake, and a 7-segment sign+hex display driver.
- Single-cycle ops: add, sub, and, or, xor, accumulate, clear.
- Multi-cycle op: signed multiply by shift-add.
- Sits between switch inputs and the SEG/LED outputs of the board top level.
- Generalises the board's combinational 3-bit ALU to NBITS operands, registered results, flags and a wider op set.

Parameters:
NBITS, 4, operand/result width in bits (signed two's complement), min 2, max 16.

Ports:
clk_2  input  1  board clock
reset_n  input  1  asynchronous reset, active-low
start  input  1  request an operation; sampled only when idle
op  input  3  operation code (see Behaviour)
a  input  NBITS  operand A, signed
b  input  NBITS  operand B, signed
busy  output  1  multiply in progress
done  output  1  one-cycle pulse: result/flags updated
result  output  NBITS  registered result / accumulator
ovf  output  1  signed overflow of last op
carry  output  1  unsigned carry-out (add/acc) or borrow (sub)
zero  output  1  result == 0
neg  output  1  result MSB
seg  output  8  7-seg pattern: bit7 = minus sign, bits6:0 = gfedcba

Behaviour:
Reset state (asynchronous, while reset_n = 0):
- result = 0, ovf/carry/neg = 0, zero = 1, busy = 0, done = 0, state = IDLE.
- seg = 0x3F.

State machine (IDLE, MUL):
- IDLE: start = 1 accepts the op at that edge and latches a, b, op.
- In MUL, start is ignored (no queueing).
- start in the cycle where done = 1 is accepted, because the block is already IDLE.

Ops:
- 000 add: a+b
- 001 sub: a-b
- 010 and
- 011 or
- 100 xor
- 101 mul: a*b
- 110 acc: result+a
- 111 clr: result = 0, flags as for a zero result

Latency:
- Non-mul ops: result and flags update at the accepting edge. done = 1 for exactly the next cycle. busy stays 0.
- mul: IDLE→MUL at the accepting edge.
  - busy = 1 for NBITS cycles; one partial-product step per cycle on operand magnitudes.
  - On the NBITS-th MUL edge: result and flags update, done = 1 for one cycle, busy = 0, state = IDLE.
  - Sign is applied at the end as a XOR b sign.
  - Magnitudes are computed in NBITS+1 bits, so the most negative value is handled.

Flags (registered together with result):
- add/acc: carry = unsigned carry-out of bit NBITS-1. ovf = operands of equal sign and result of different sign.
- sub: carry = borrow (a < b unsigned). ovf per signed subtraction rule.
- and/or/xor/clr: ovf = 0, carry = 0.
- mul: ovf = 1 when the full 2*NBITS signed product does not fit NBITS signed. carry = 0. result = low NBITS bits of the product.
- zero and neg always reflect the new result.

Display (combinational from result):
- bit7 = neg.
- Bits 6:0 show the low hex digit of |result|, computed in NBITS+1 bits.
- Digit codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.

Reset mid-operation: aborts MUL immediately. No done pulse; all outputs take their reset values.

Optional Feature:
ULA_SAT_EN:
- Defined: add, sub, acc and mul saturate on overflow. Result clamps to 2^(NBITS-1)-1 when the true value is positive, and to -2^(NBITS-1) when negative. ovf is still set to 1.
- Undefined: results wrap modulo 2^NBITS. ovf flags the wrap.
- Logic ops are unaffected either way.

Test Plan:
1. NBITS=4, a=3, b=2, op=000, start pulse → next cycle result=0x5, seg=0x6D, done=1 for one cycle, busy=0, ovf=carry=neg=0.
2. a=2, b=3, op=001 → result=0xF, seg=0x86, neg=1, carry=1, ovf=0.
3. a=7, b=1, op=000 → without SAT: result=0x8, ovf=1, seg=0xFF. With ULA_SAT_EN: result=0x7, ovf=1, seg=0x07.
4. a=-3 (0xD), b=2, op=101 → busy=1 for 4 cycles, then result=0xA, seg=0xFD, done pulse, ovf=0. A start pulse with op=000 during busy is ignored: result unchanged, only one done pulse.
5. Accumulate sequence:
   - op=111 → result=0, zero=1.
   - op=110, a=5 → result=5.
   - op=110, a=5 → wrap: result=0xA, ovf=1. SAT: result=0x7.
6. Reset mid-multiply: start mul, drop reset_n in the 2nd busy cycle → busy=0, result=0, zero=1, seg=0x3F immediately, no done pulse after reset release.

Source files
------------

// File: rtl/ula_seq_seg.sv
// Signed sequential ALU: single-cycle add/sub/logic/acc/clr, shift-add multiply, sign+hex 7-seg.
// Optional build macro ULA_SAT_EN: saturate add/sub/acc/mul on signed overflow instead of wrapping.
module ula_seq_seg #(
  parameter int NBITS = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result,
  output logic             ovf,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic [7:0]       seg
);
  localparam int N  = NBITS;
  localparam int W2 = 2 * NBITS;
  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};
  localparam logic [4:0]   LAST = 5'(N - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state_q;
  logic           busy_q, done_q, ovf_q, carry_q, sgn_q;
  logic [N-1:0]   result_q;
  logic [W2-1:0]  mcand_q, prod_q;
  logic [N:0]     mplier_q;
  logic [4:0]     cnt_q;

  logic [N:0]     sum, diff, accs, ax, bx, maga, magb;
  logic [N-1:0]   alu_res, mul_res;
  logic           alu_ovf, alu_c, sat_neg, mul_ovf;
  logic [W2-1:0]  prod_nx, sprod;

  assign ax   = {a[N-1], a};
  assign bx   = {b[N-1], b};
  assign maga = a[N-1] ? -ax : ax;
  assign magb = b[N-1] ? -bx : bx;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    accs    = {1'b0, result_q} + {1'b0, a};
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_c   = 1'b0;
    sat_neg = 1'b0;
    case (op)
      3'b000: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        sat_neg = a[N-1];
      end
      3'b001: begin
        alu_res = diff[N-1:0];
        alu_c   = diff[N];
        alu_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
        sat_neg = a[N-1];
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      3'b110: begin
        alu_res = accs[N-1:0];
        alu_c   = accs[N];
        alu_ovf = (result_q[N-1] == a[N-1]) && (accs[N-1] != a[N-1]);
        sat_neg = a[N-1];
      end
      default: alu_res = '0;
    endcase
`ifdef ULA_SAT_EN
    if (alu_ovf) alu_res = sat_neg ? MINV : MAXV;
`endif
  end

  // Final multiply step is folded in combinationally so the result lands on the NBITS-th MUL edge.
  always_comb begin
    prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
    sprod   = sgn_q ? -prod_nx : prod_nx;
    mul_ovf = !((&sprod[W2-1:N-1]) || !(|sprod[W2-1:N-1]));
    mul_res = sprod[N-1:0];
`ifdef ULA_SAT_EN
    if (mul_ovf) mul_res = sgn_q ? MINV : MAXV;
`endif
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (op == 3'b101) begin
            state_q  <= MUL;
            busy_q   <= 1'b1;
            mcand_q  <= W2'(maga);
            mplier_q <= magb;
            prod_q   <= '0;
            cnt_q    <= '0;
            sgn_q    <= a[N-1] ^ b[N-1];
          end else begin
            result_q <= alu_res;
            ovf_q    <= alu_ovf;
            carry_q  <= alu_c;
            done_q   <= 1'b1;
          end
        end
        MUL: begin
          prod_q   <= prod_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            result_q <= mul_res;
            ovf_q    <= mul_ovf;
            carry_q  <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only the low hex digit of |result| is shown, so 4-bit negation is exact.
  logic [3:0] r4, dig;
  generate
    if (N >= 4) begin : g_wide
      assign r4 = result_q[3:0];
    end else begin : g_narrow
      assign r4 = {{(4-N){result_q[N-1]}}, result_q};
    end
  endgenerate
  assign dig = result_q[N-1] ? (~r4 + 4'd1) : r4;

  logic [6:0] segs;
  always_comb begin
    case (dig)
      4'h0: segs = 7'h3F;  4'h1: segs = 7'h06;  4'h2: segs = 7'h5B;  4'h3: segs = 7'h4F;
      4'h4: segs = 7'h66;  4'h5: segs = 7'h6D;  4'h6: segs = 7'h7D;  4'h7: segs = 7'h07;
      4'h8: segs = 7'h7F;  4'h9: segs = 7'h6F;  4'hA: segs = 7'h77;  4'hB: segs = 7'h7C;
      4'hC: segs = 7'h39;  4'hD: segs = 7'h5E;  4'hE: segs = 7'h79;  default: segs = 7'h71;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign carry  = carry_q;
  assign zero   = (result_q == '0);
  assign neg    = result_q[N-1];
  assign seg    = {result_q[N-1], segs};
endmodule

// File: tb/tb_ula_seq_seg.sv
// Scoreboard bench for ula_seq_seg (NBITS=4): stimulus pushes expectations, monitor pops on done.
module tb_ula_seq_seg;
`ifdef ULA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       busy, done, ovf, carry, zero, neg;
  logic [3:0] result;
  logic [7:0] seg;

  ula_seq_seg #(.NBITS(4)) dut (
    .clk_2(clk), .reset_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .carry(carry),
    .zero(zero), .neg(neg), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic       ovf, c, z, n;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, dones = 0, pushed = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic o, input logic c, input logic [7:0] s);
    mk = '{r: r, ovf: o, c: c, z: (r == 4'd0), n: r[3], seg: s};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      dones++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 want no pending op at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("result", 16'(result), 16'(e.r));
        chk("ovf",    16'(ovf),    16'(e.ovf));
        chk("carry",  16'(carry),  16'(e.c));
        chk("zero",   16'(zero),   16'(e.z));
        chk("neg",    16'(neg),    16'(e.n));
        chk("seg",    16'(seg),    16'(e.seg));
        chk("busy_at_done", 16'(busy), 16'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                       input bit push, input exp_t e);
    @(negedge clk);
    if (push) begin
      q.push_back(e);
      pushed++;
    end
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got busy=1 want 0 within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", 16'(busy), 16'd0);   chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", 16'(result), 16'd0); chk("rst_ovf", 16'(ovf), 16'd0);
    chk("rst_carry", 16'(carry), 16'd0); chk("rst_zero", 16'(zero), 16'd1);
    chk("rst_neg", 16'(neg), 16'd0);     chk("rst_seg", 16'(seg), 16'h3F);
    @(negedge clk) rst_n = 1'b1;

    // add 3+2, then check done is a single-cycle pulse
    issue(3'b000, 4'd3, 4'd2, 1, mk(4'h5, 0, 0, 8'h6D));
    chk("t1_busy", 16'(busy), 16'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse", 16'(done), 16'd0);

    issue(3'b001, 4'd2, 4'd3, 1, mk(4'hF, 0, 1, 8'h86));
    issue(3'b000, 4'd7, 4'd1, 1, SAT ? mk(4'h7, 1, 0, 8'h07) : mk(4'h8, 1, 0, 8'hFF));
    issue(3'b000, 4'h8, 4'h8, 1, SAT ? mk(4'h8, 1, 1, 8'hFF) : mk(4'h0, 1, 1, 8'h3F));
    issue(3'b001, 4'h8, 4'h1, 1, SAT ? mk(4'h8, 1, 0, 8'hFF) : mk(4'h7, 1, 0, 8'h07));
    issue(3'b010, 4'hC, 4'hA, 1, mk(4'h8, 0, 0, 8'hFF));
    issue(3'b011, 4'h5, 4'h2, 1, mk(4'h7, 0, 0, 8'h07));
    issue(3'b100, 4'hF, 4'h5, 1, mk(4'hA, 0, 0, 8'hFD));

    // mul -3*2 with an ignored start in the 2nd busy cycle
    issue(3'b101, 4'hD, 4'h2, 1, mk(4'hA, 0, 0, 8'hFD));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_busy", 16'(busy), 16'd1);
      chk("mul_nodone", 16'(done), 16'd0);
      if (i == 1) begin
        op = 3'b000; a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    @(negedge clk);
    chk("mul_busy_end", 16'(busy), 16'd0);

    issue(3'b101, 4'h8, 4'h8, 1, SAT ? mk(4'h7, 1, 0, 8'h07) : mk(4'h0, 1, 0, 8'h3F));
    wait_idle();
    issue(3'b101, 4'h8, 4'h1, 1, mk(4'h8, 0, 0, 8'hFF));
    wait_idle();

    issue(3'b111, 4'h3, 4'h3, 1, mk(4'h0, 0, 0, 8'h3F));
    issue(3'b110, 4'h5, 4'h0, 1, mk(4'h5, 0, 0, 8'h6D));
    issue(3'b110, 4'h5, 4'h0, 1, SAT ? mk(4'h7, 1, 0, 8'h07) : mk(4'hA, 1, 0, 8'hFD));
    repeat (2) @(negedge clk);

    // reset in the 2nd busy cycle of a multiply
    issue(3'b101, 4'h3, 4'h3, 0, mk(4'h0, 0, 0, 8'h00));
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_busy", 16'(busy), 16'd0);  chk("rmid_done", 16'(done), 16'd0);
    chk("rmid_result", 16'(result), 16'd0); chk("rmid_zero", 16'(zero), 16'd1);
    chk("rmid_seg", 16'(seg), 16'h3F);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rmid_busy_after", 16'(busy), 16'd0);

    chk("done_count", 16'(dones), 16'(pushed));
    chk("queue_empty", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
